// File: rtl/grid_erosion_pkg.sv
// grid_erosion_pkg: shared FSM states, count-width helper and neighbour-count type for the erosion engine
package grid_erosion_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, SWEEP, CHECK, DUMP, DONE} state_t;

    typedef logic [3:0] ncnt_t;

    function automatic int cnt_w(input int w, input int d);
        return $clog2(w * d + 1);
    endfunction

endpackage

// File: rtl/erosion_row_kernel.sv
// erosion_row_kernel: combinational erosion of one row given its pre-sweep neighbours
//   above/cur/below : pre-sweep rows r-1, r, r+1
//   above_vld/below_vld : low at the top/bottom grid edge (missing row counts as empty)
//   new_row : cur with under-supported cells cleared
//   removed : number of cells cleared in this row
module erosion_row_kernel
    import grid_erosion_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int THRESH = 4,
    localparam int KW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] above,
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] below,
    input  logic             above_vld,
    input  logic             below_vld,
    output logic [WIDTH-1:0] new_row,
    output logic [KW-1:0]    removed
);
    logic [WIDTH+1:0] a, c, b;
    logic [WIDTH-1:0] kill;

    // one zero column of padding on each side makes off-grid neighbours read as empty
    assign a = {1'b0, above & {WIDTH{above_vld}}, 1'b0};
    assign c = {1'b0, cur, 1'b0};
    assign b = {1'b0, below & {WIDTH{below_vld}}, 1'b0};

    for (genvar j = 0; j < WIDTH; j++) begin : g_col
        ncnt_t n;
        assign n = ncnt_t'(a[j]) + ncnt_t'(a[j+1]) + ncnt_t'(a[j+2])
                 + ncnt_t'(c[j]) + ncnt_t'(c[j+2])
                 + ncnt_t'(b[j]) + ncnt_t'(b[j+1]) + ncnt_t'(b[j+2]);
        assign kill[j] = cur[j] && (n < ncnt_t'(THRESH));
    end

    assign new_row = cur & ~kill;

    always_comb begin
        removed = '0;
        for (int i = 0; i < WIDTH; i++) removed = removed + KW'(kill[i]);
    end

endmodule

// File: rtl/grid_erosion_engine.sv
// grid_erosion_engine: stream-loaded grid, repeated erosion sweeps until stable, removal statistics
//   clk, rst_n (async active-low) ; start : begin a job (IDLE/DONE only)
//   row_valid/row_ready/row_data : row-by-row grid load, row 0 first
//   busy, done : job status ; first_removed, total_removed, sweep_count : results, valid while done
//   GRID_EROSION_DUMP_EN : adds dump_valid/dump_ready/dump_data to stream out the final grid
module grid_erosion_engine
    import grid_erosion_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int THRESH = 4,
    localparam int CW    = cnt_w(WIDTH, DEPTH),
    localparam int SW    = CW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             row_valid,
    output logic             row_ready,
    input  logic [WIDTH-1:0] row_data,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    first_removed,
    output logic [CW-1:0]    total_removed,
    output logic [SW-1:0]    sweep_count
`ifdef GRID_EROSION_DUMP_EN
    ,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [WIDTH-1:0] dump_data
`endif
);
    localparam int RW = $clog2(DEPTH);
    localparam int KW = $clog2(WIDTH + 1);
    localparam logic [RW-1:0] LAST = RW'(DEPTH - 1);

    state_t state, state_n;
    logic [RW-1:0] row, row_nx;
    logic [CW-1:0] acc;
    logic [WIDTH-1:0] grid [DEPTH];
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] new_row;
    logic [KW-1:0] kcnt;
    logic go;

    assign row_nx    = (row == LAST) ? '0 : row + 1'b1;
    assign go        = (state == IDLE || state == DONE) && start;
    assign row_ready = state == LOAD;
    assign busy      = state inside {LOAD, SWEEP, CHECK, DUMP};
    assign done      = state == DONE;
`ifdef GRID_EROSION_DUMP_EN
    assign dump_valid = state == DUMP;
    assign dump_data  = grid[row];
`endif

    // shadow holds the pre-sweep copy of row r-1, which was overwritten last cycle
    erosion_row_kernel #(.WIDTH(WIDTH), .THRESH(THRESH)) u_kernel (
        .above     (shadow),
        .cur       (grid[row]),
        .below     (grid[row_nx]),
        .above_vld (row != '0),
        .below_vld (row != LAST),
        .new_row   (new_row),
        .removed   (kcnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: state_n = start ? LOAD : state;
            LOAD:       state_n = (row_valid && row == LAST) ? SWEEP : LOAD;
            SWEEP:      state_n = (row == LAST) ? CHECK : SWEEP;
`ifdef GRID_EROSION_DUMP_EN
            CHECK:      state_n = (acc != '0) ? SWEEP : DUMP;
            DUMP:       state_n = (dump_ready && row == LAST) ? DONE : DUMP;
`else
            CHECK:      state_n = (acc != '0) ? SWEEP : DONE;
`endif
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row           <= '0;
            acc           <= '0;
            first_removed <= '0;
            total_removed <= '0;
            sweep_count   <= '0;
        end else begin
            if (go) begin
                row           <= '0;
                acc           <= '0;
                first_removed <= '0;
                total_removed <= '0;
                sweep_count   <= '0;
            end
            if (state == LOAD && row_valid) row <= row_nx;
            if (state == SWEEP) begin
                row <= row_nx;
                acc <= acc + CW'(kcnt);
            end
            if (state == CHECK) begin
                total_removed <= total_removed + acc;
                // an empty sweep ends the job, so no productive sweep yet means this is sweep 1
                if (sweep_count == '0) first_removed <= acc;
                if (acc != '0) sweep_count <= sweep_count + 1'b1;
                acc <= '0;
            end
`ifdef GRID_EROSION_DUMP_EN
            if (state == DUMP && dump_ready) row <= row_nx;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOAD && row_valid) grid[row] <= row_data;
        if (state == SWEEP) begin
            grid[row] <= new_row;
            shadow    <= grid[row];
        end
    end

endmodule
